comp_strg_ext: RTL



---
 rtl/comp_strg_ext_if.sv | 24 ++
 rtl/comp_strg_ext.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/comp_strg_ext_if.sv
// Host command bundle for comp_strg_ext: strobe, opcode, operand addresses and
// the status returned by the engine.
interface comp_strg_ext_if #(
  parameter int ADDR_WIDTH = 4
);
  logic                  en;
  logic [2:0]            cmd;
  logic [ADDR_WIDTH-1:0] addA;
  logic [ADDR_WIDTH-1:0] addB;
  logic [ADDR_WIDTH-1:0] addC;
  logic                  valid_out;
  logic                  busy;
  logic                  ovf;

  modport master (
    output en, cmd, addA, addB, addC,
    input  valid_out, busy, ovf
  );

  modport slave (
    input  en, cmd, addA, addB, addC,
    output valid_out, busy, ovf
  );
endinterface

// File: rtl/comp_strg_ext.sv
// Computation-storage engine: register file with in-place ADD/SUB/MUL/MAC/CLR,
// shared bidirectional DQ bus and a busy handshake.
module comp_strg_ext #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 4,
  parameter bit SAT_EN     = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  comp_strg_ext_if.slave        bus,
  inout  wire  [DATA_WIDTH-1:0] DQ
);
  localparam int W     = DATA_WIDTH;
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int CW    = $clog2(W + 1);

  localparam logic [2:0] OP_WRITE = 3'b000;
  localparam logic [2:0] OP_READ  = 3'b001;
  localparam logic [2:0] OP_ADD   = 3'b010;
  localparam logic [2:0] OP_SUB   = 3'b011;
  localparam logic [2:0] OP_MUL   = 3'b100;
  localparam logic [2:0] OP_MAC   = 3'b101;
  localparam logic [2:0] OP_CLR   = 3'b110;

  typedef enum logic [2:0] {S_IDLE, S_RD, S_EXEC, S_ITER, S_WB} state_t;

  state_t                state;
  logic                  busy_q;
  logic                  valid_q;
  logic                  ovf_q;
  logic                  dq_oe;
  logic                  is_sub;
  logic                  is_mac;
  logic [CW-1:0]         cnt;
  logic [ADDR_WIDTH-1:0] dst;
  logic [W-1:0]          mem [DEPTH];

  logic [W-1:0]          opa_p0;
  logic [W-1:0]          opb_p0;
  logic [W-1:0]          opc_p0;
  logic [2*W-1:0]        acc_p1;
  logic [2*W-1:0]        mcand_p1;
  logic [W-1:0]          mplier_p1;

  logic                  accept;
  logic [W:0]            res_addsub;
  logic [W:0]            res_wide;

  // Each returns {ovf, result}.
  function automatic logic [W:0] sat_add(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s[W] && SAT_EN) return {1'b1, {W{1'b1}}};
    return s;
  endfunction

  function automatic logic [W:0] sat_sub(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W:0] d;
    d = {1'b0, a} - {1'b0, b};
    if (d[W] && SAT_EN) return {1'b1, {W{1'b0}}};
    return d;
  endfunction

  function automatic logic [W:0] sat_wide(input logic [2*W:0] v);
    logic o;
    o = |v[2*W:W];
    if (o && SAT_EN) return {1'b1, {W{1'b1}}};
    return {o, v[W-1:0]};
  endfunction

  assign accept = bus.en && !busy_q && (state == S_IDLE);

  assign res_addsub = is_sub ? sat_sub(opa_p0, opb_p0) : sat_add(opa_p0, opb_p0);
  assign res_wide   = sat_wide(is_mac ? ({1'b0, acc_p1} + {{(W+1){1'b0}}, opc_p0})
                                      : {1'b0, acc_p1});

  assign bus.busy      = busy_q;
  assign bus.valid_out = valid_q;
  assign bus.ovf       = ovf_q;
  assign DQ            = dq_oe ? opa_p0 : {W{1'bz}};

  // Control and storage: the only state touched by reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
      dq_oe   <= 1'b0;
      is_sub  <= 1'b0;
      is_mac  <= 1'b0;
      cnt     <= '0;
      dst     <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
      dq_oe   <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            case (bus.cmd)
              OP_WRITE: mem[bus.addA] <= DQ;
              OP_CLR:   mem[bus.addC] <= '0;
              OP_READ: begin
                state   <= S_RD;
                busy_q  <= 1'b1;
                valid_q <= 1'b1;
                dq_oe   <= 1'b1;
              end
              OP_ADD, OP_SUB: begin
                state  <= S_EXEC;
                busy_q <= 1'b1;
                is_sub <= bus.cmd[0];
                dst    <= bus.addC;
              end
              OP_MUL, OP_MAC: begin
                state  <= S_ITER;
                busy_q <= 1'b1;
                is_mac <= bus.cmd[0];
                dst    <= bus.addC;
                cnt    <= '0;
              end
              default: ;
            endcase
          end
        end
        S_RD: begin
          state  <= S_IDLE;
          busy_q <= 1'b0;
        end
        S_EXEC: begin
          mem[dst] <= res_addsub[W-1:0];
          valid_q  <= 1'b1;
          ovf_q    <= res_addsub[W];
          busy_q   <= 1'b0;
          state    <= S_IDLE;
        end
        S_ITER: begin
          cnt <= cnt + 1'b1;
          if (cnt == CW'(W - 1)) state <= S_WB;
        end
        S_WB: begin
          mem[dst] <= res_wide[W-1:0];
          valid_q  <= 1'b1;
          ovf_q    <= res_wide[W];
          busy_q   <= 1'b0;
          state    <= S_IDLE;
        end
        default: begin
          state  <= S_IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  // p0: operands captured at acceptance; p1: radix-2 shift-add, one multiplier bit per cycle.
  always_ff @(posedge clk) begin
    if (accept) begin
      opa_p0    <= mem[bus.addA];
      opb_p0    <= mem[bus.addB];
      opc_p0    <= mem[bus.addC];
      acc_p1    <= '0;
      mcand_p1  <= {{W{1'b0}}, mem[bus.addA]};
      mplier_p1 <= mem[bus.addB];
    end else if (state == S_ITER) begin
      if (mplier_p1[0]) acc_p1 <= acc_p1 + mcand_p1;
      mcand_p1  <= mcand_p1 << 1;
      mplier_p1 <= mplier_p1 >> 1;
    end
  end
endmodule
